axis_frame_classifier: RTL and testbench

//   Passive AXI-Stream monitor; classifies each frame from its first beat by EtherType.

---
 rtl/tsn_cls_pkg.sv | 13 +
 rtl/axis_sat_counter.sv | 25 ++
 rtl/axis_frame_classifier.sv | 176 +++++++++++++++++
 tb/tb_axis_frame_classifier.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsn_cls_pkg.sv
// Shared constants and types for the AXI-Stream frame classifier.
package tsn_cls_pkg;

    localparam logic [15:0] ETYPE_VLAN = 16'h8100;
    localparam logic [15:0] ETYPE_CRIT = 16'h66AB;
    localparam logic [15:0] ETYPE_PTP  = 16'h88F7;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } cls_state_t;

endpackage : tsn_cls_pkg

// File: rtl/axis_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module axis_sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] q
);

    // Count register: clear first, then increment unless already all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= {CNT_WIDTH{1'b0}};
        end else if (clr) begin
            q <= {CNT_WIDTH{1'b0}};
        end else if (inc && (q != {CNT_WIDTH{1'b1}})) begin
            q <= q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            q <= q;
        end
    end

endmodule : axis_sat_counter

// File: rtl/axis_frame_classifier.sv
// Passive AXI-Stream frame classifier. Looks at the first beat of each frame,
// strips an optional 802.1Q tag and matches the EtherType against a small
// programmable rule table. Results are registered one cycle after the first
// beat and held until the next frame.
// Optional feature macro: AXIS_CLS_COUNTERS_EN adds per-class frame counters.
module axis_frame_classifier
    import tsn_cls_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int NUM_RULES  = 4,
    parameter int CNT_WIDTH  = 32,
    localparam int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                      axis_aclk,
    input  logic                      rstn,
    input  logic                      axis_tvalid,
    input  logic                      axis_tready,
    input  logic [DATA_WIDTH-1:0]     axis_tdata,
    input  logic                      axis_tlast,
    input  logic [16*NUM_RULES-1:0]   cfg_rule_etype,
    input  logic [NUM_RULES-1:0]      cfg_rule_en,
    output logic                      cls_valid,
    output logic                      cls_hit,
    output logic [IDX_W-1:0]          cls_rule_idx,
    output logic                      cls_vlan,
    output logic [2:0]                cls_pcp,
    output logic                      is_it_frame
`ifdef AXIS_CLS_COUNTERS_EN
    ,
    input  logic                      cnt_clear,
    output logic [CNT_WIDTH-1:0]      cnt_it,
    output logic [CNT_WIDTH*NUM_RULES-1:0] cnt_rule
`endif
);

    cls_state_t       state_r;
    cls_state_t       state_nxt_s;
    logic             beat_s;
    logic             first_beat_s;
    logic [15:0]      et1_s;
    logic [15:0]      et_s;
    logic             vlan_s;
    logic [2:0]       pcp_s;
    logic             hit_s;
    logic [IDX_W-1:0] idx_s;
    logic             unused_tdata_s;

    assign beat_s       = axis_tvalid && axis_tready;
    assign first_beat_s = beat_s && (state_r == IDLE);

    // Only bytes 12..17 of the first beat matter; the rest is ignored on purpose.
    assign unused_tdata_s = ^axis_tdata;

    // State register: tracks whether the next accepted beat starts a frame.
    always_ff @(posedge axis_aclk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: a non-last beat opens a frame, a last beat closes it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (beat_s && !axis_tlast) begin
                    state_nxt_s = IN_FRAME;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IN_FRAME: begin
                if (beat_s && axis_tlast) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = IN_FRAME;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Header decode: outer EtherType, optional VLAN tag, effective EtherType.
    always_comb begin
        et1_s  = {axis_tdata[8*12 +: 8], axis_tdata[8*13 +: 8]};
        vlan_s = 1'b0;
        pcp_s  = 3'd0;
        et_s   = et1_s;
        if (et1_s == ETYPE_VLAN) begin
            vlan_s = 1'b1;
            pcp_s  = axis_tdata[8*14+5 +: 3];
            et_s   = {axis_tdata[8*16 +: 8], axis_tdata[8*17 +: 8]};
        end else begin
            vlan_s = 1'b0;
            pcp_s  = 3'd0;
            et_s   = et1_s;
        end
    end

    // Rule match: scan from the top so the lowest matching index is left last.
    always_comb begin
        hit_s = 1'b0;
        idx_s = {IDX_W{1'b0}};
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (cfg_rule_en[i] && (cfg_rule_etype[16*i +: 16] == et_s)) begin
                hit_s = 1'b1;
                idx_s = IDX_W'(i);
            end else begin
                hit_s = hit_s;
                idx_s = idx_s;
            end
        end
    end

    // Result registers: pulse on the first beat, hold classification otherwise.
    always_ff @(posedge axis_aclk or negedge rstn) begin
        if (!rstn) begin
            cls_valid    <= 1'b0;
            cls_hit      <= 1'b0;
            cls_rule_idx <= {IDX_W{1'b0}};
            cls_vlan     <= 1'b0;
            cls_pcp      <= 3'd0;
            is_it_frame  <= 1'b1;
        end else if (first_beat_s) begin
            cls_valid    <= 1'b1;
            cls_hit      <= hit_s;
            cls_rule_idx <= idx_s;
            cls_vlan     <= vlan_s;
            cls_pcp      <= pcp_s;
            is_it_frame  <= !hit_s;
        end else begin
            cls_valid    <= 1'b0;
            cls_hit      <= cls_hit;
            cls_rule_idx <= cls_rule_idx;
            cls_vlan     <= cls_vlan;
            cls_pcp      <= cls_pcp;
            is_it_frame  <= is_it_frame;
        end
    end

`ifdef AXIS_CLS_COUNTERS_EN
    logic [NUM_RULES-1:0] rule_inc_s;
    logic                 it_inc_s;

    assign it_inc_s = cls_valid && !cls_hit;

    axis_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt_it (
        .clk  (axis_aclk),
        .rstn (rstn),
        .inc  (it_inc_s),
        .clr  (cnt_clear),
        .q    (cnt_it)
    );

    for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule_cnt
        assign rule_inc_s[g] = cls_valid && cls_hit && (cls_rule_idx == IDX_W'(g));

        axis_sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt_rule (
            .clk  (axis_aclk),
            .rstn (rstn),
            .inc  (rule_inc_s[g]),
            .clr  (cnt_clear),
            .q    (cnt_rule[g*CNT_WIDTH +: CNT_WIDTH])
        );
    end
`endif

endmodule : axis_frame_classifier

// File: tb/tb_axis_frame_classifier.sv
// Scoreboard bench for axis_frame_classifier. Build with AXIS_CLS_COUNTERS_EN
// defined to also exercise the counters (a narrow CNT_WIDTH keeps saturation short).
module tb_axis_frame_classifier;

    localparam int DW    = 256;
    localparam int NR    = 4;
    localparam int CW    = 4;
    localparam logic [8:0] RST_OUT = 9'b0_0_00_0_000_1;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           axis_tvalid = 1'b0;
    logic           axis_tready = 1'b0;
    logic [DW-1:0]  axis_tdata = '0;
    logic           axis_tlast = 1'b0;
    logic [16*NR-1:0] cfg_rule_etype = '0;
    logic [NR-1:0]  cfg_rule_en = '0;
    logic           cls_valid;
    logic           cls_hit;
    logic [1:0]     cls_rule_idx;
    logic           cls_vlan;
    logic [2:0]     cls_pcp;
    logic           is_it_frame;
`ifdef AXIS_CLS_COUNTERS_EN
    logic           cnt_clear = 1'b0;
    logic [CW-1:0]  cnt_it;
    logic [CW*NR-1:0] cnt_rule;
`endif

    int vec = 0;
    int err = 0;
    logic [8:0] exp_q[$];
    logic [8:0] last_m = RST_OUT;
    logic       in_frame_m = 1'b0;

    axis_frame_classifier #(
        .DATA_WIDTH (DW),
        .NUM_RULES  (NR),
        .CNT_WIDTH  (CW)
    ) dut (
        .axis_aclk      (clk),
        .rstn           (rstn),
        .axis_tvalid    (axis_tvalid),
        .axis_tready    (axis_tready),
        .axis_tdata     (axis_tdata),
        .axis_tlast     (axis_tlast),
        .cfg_rule_etype (cfg_rule_etype),
        .cfg_rule_en    (cfg_rule_en),
        .cls_valid      (cls_valid),
        .cls_hit        (cls_hit),
        .cls_rule_idx   (cls_rule_idx),
        .cls_vlan       (cls_vlan),
        .cls_pcp        (cls_pcp),
        .is_it_frame    (is_it_frame)
`ifdef AXIS_CLS_COUNTERS_EN
        ,
        .cnt_clear      (cnt_clear),
        .cnt_it         (cnt_it),
        .cnt_rule       (cnt_rule)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [8:0] obs();
        return {cls_valid, cls_hit, cls_rule_idx, cls_vlan, cls_pcp, is_it_frame};
    endfunction

    // Reference classification of a first beat.
    function automatic logic [8:0] model(logic [DW-1:0] d, logic [16*NR-1:0] et, logic [NR-1:0] en);
        logic [15:0] et1, etv;
        logic vl, h;
        logic [2:0] p;
        logic [1:0] ix;
        et1 = {d[103:96], d[111:104]};
        vl  = (et1 == 16'h8100);
        p   = vl ? d[119:117] : 3'd0;
        etv = vl ? {d[135:128], d[143:136]} : et1;
        h = 1'b0;
        ix = 2'd0;
        for (int i = 0; i < NR; i++) begin
            if (!h && en[i] && (et[16*i +: 16] == etv)) begin
                h = 1'b1;
                ix = i[1:0];
            end
        end
        return {1'b1, h, ix, vl, p, !h};
    endfunction

    function automatic logic [DW-1:0] mk(logic [15:0] et1, logic [7:0] b14, logic [15:0] et2);
        logic [DW-1:0] d;
        for (int w = 0; w < DW/32; w++) d[32*w +: 32] = $urandom;
        d[103:96]  = et1[15:8];
        d[111:104] = et1[7:0];
        d[119:112] = b14;
        d[135:128] = et2[15:8];
        d[143:136] = et2[7:0];
        return d;
    endfunction

    // Expected output this cycle: pop a pending classification or hold the last one.
    task automatic expect_now(output logic [8:0] e);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_m = {1'b0, e[7:0]};
        end else begin
            e = last_m;
        end
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic last);
        axis_tvalid = 1'b1;
        axis_tready = 1'b1;
        axis_tdata  = d;
        axis_tlast  = last;
        if (!in_frame_m) exp_q.push_back(model(d, cfg_rule_etype, cfg_rule_en));
        in_frame_m = !last;
        @(posedge clk);
        #1;
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
    endtask

    task automatic idle_cycle();
        axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rules(input logic [15:0] r0, r1, r2, r3, input logic [3:0] en);
        cfg_rule_etype = {r3, r2, r1, r0};
        cfg_rule_en    = en;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if (obs() !== RST_OUT) begin
            err++;
            $display("FAIL reset_state: got %b want %b", obs(), RST_OUT);
        end
        rstn = 1'b1;
        idle_cycle();
    endtask

    task automatic test_crit_multibeat();
        logic [8:0] e;
        set_rules(16'h66AB, 16'h88F7, 16'h0000, 16'h0000, 4'b0011);
        drive_beat(mk(16'h66AB, 8'h00, 16'h0000), 1'b0);
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL crit_first: got %b want %b", obs(), e); end
        // Rule changes mid-frame must not reclassify; mid-frame beats look like headers.
        cfg_rule_en = 4'b0000;
        for (int b = 1; b < 4; b++) begin
            drive_beat(mk(16'h0800, 8'h00, 16'h0000), (b == 3));
            expect_now(e);
            vec++;
            if (obs() !== e) begin err++; $display("FAIL crit_mid%0d: got %b want %b", b, obs(), e); end
        end
        set_rules(16'h66AB, 16'h88F7, 16'h0000, 16'h0000, 4'b0011);
    endtask

    task automatic test_vlan_back_to_back();
        logic [8:0] e;
        drive_beat(mk(16'h8100, 8'hA0, 16'h88F7), 1'b1);
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL vlan_ptp: got %b want %b", obs(), e); end
        drive_beat(mk(16'h8100, 8'hE0, 16'h0800), 1'b1);
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL vlan_miss_b2b: got %b want %b", obs(), e); end
        drive_beat(mk(16'h66AB, 8'h20, 16'h88F7), 1'b1);
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL b2b_third: got %b want %b", obs(), e); end
        idle_cycle();
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL b2b_hold: got %b want %b", obs(), e); end
    endtask

    task automatic test_it_frame();
        logic [8:0] e;
`ifdef AXIS_CLS_COUNTERS_EN
        cnt_clear = 1'b1;
        idle_cycle();
        cnt_clear = 1'b0;
        expect_now(e);
        vec++;
        if (cnt_it !== 4'd0) begin err++; $display("FAIL cnt_it_clr: got %0d want 0", cnt_it); end
`endif
        drive_beat(mk(16'h0800, 8'hFF, 16'h88F7), 1'b1);
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL it_frame: got %b want %b", obs(), e); end
        idle_cycle();
        expect_now(e);
`ifdef AXIS_CLS_COUNTERS_EN
        vec++;
        if (cnt_it !== 4'd1) begin err++; $display("FAIL cnt_it_inc: got %0d want 1", cnt_it); end
`endif
        vec++;
        if (obs() !== e) begin err++; $display("FAIL it_hold: got %b want %b", obs(), e); end
    endtask

    task automatic test_backpressure();
        logic [8:0] e;
        logic [DW-1:0] d;
        d = mk(16'h88F7, 8'h00, 16'h0000);
        axis_tvalid = 1'b1;
        axis_tready = 1'b0;
        axis_tdata  = d;
        axis_tlast  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            expect_now(e);
            vec++;
            if (obs() !== e) begin err++; $display("FAIL bp_stall%0d: got %b want %b", c, obs(), e); end
        end
        drive_beat(d, 1'b1);
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL bp_accept: got %b want %b", obs(), e); end
        idle_cycle();
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL bp_single: got %b want %b", obs(), e); end
    endtask

    task automatic test_priority();
        logic [8:0] e;
        logic [3:0] ens[4];
        ens[0] = 4'b0101;
        ens[1] = 4'b0100;
        ens[2] = 4'b1000;
        ens[3] = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            set_rules(16'h1234, 16'h1234, 16'h1234, 16'h1234, ens[k]);
            drive_beat(mk(16'h8100, 8'h60, 16'h1234), 1'b1);
            expect_now(e);
            vec++;
            if (obs() !== e) begin err++; $display("FAIL prio%0d: got %b want %b", k, obs(), e); end
        end
        set_rules(16'h1234, 16'h1234, 16'h1234, 16'h1234, 4'b0000);
        drive_beat(mk(16'h1234, 8'h00, 16'h0000), 1'b1);
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL prio_disabled: got %b want %b", obs(), e); end
        set_rules(16'h66AB, 16'h88F7, 16'h0000, 16'h0000, 4'b0011);
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] e;
        drive_beat(mk(16'h66AB, 8'h00, 16'h0000), 1'b0);
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL rm_first: got %b want %b", obs(), e); end
        drive_beat(mk(16'h0800, 8'h00, 16'h0000), 1'b0);
        expect_now(e);
        axis_tvalid = 1'b1;
        axis_tready = 1'b1;
        axis_tdata  = mk(16'h0800, 8'h00, 16'h0000);
        #2;
        rstn = 1'b0;
        #1;
        vec++;
        if (obs() !== RST_OUT) begin err++; $display("FAIL rm_reset: got %b want %b", obs(), RST_OUT); end
        exp_q.delete();
        in_frame_m = 1'b0;
        last_m = RST_OUT;
        axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive_beat(mk(16'h8100, 8'h40, 16'h88F7), 1'b0);
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL rm_new_first: got %b want %b", obs(), e); end
        drive_beat(mk(16'h66AB, 8'h00, 16'h0000), 1'b1);
        expect_now(e);
        vec++;
        if (obs() !== e) begin err++; $display("FAIL rm_new_last: got %b want %b", obs(), e); end
    endtask

`ifdef AXIS_CLS_COUNTERS_EN
    task automatic test_counters();
        logic [8:0] e;
        set_rules(16'h66AB, 16'h88F7, 16'h0000, 16'h0000, 4'b0011);
        cnt_clear = 1'b1;
        idle_cycle();
        cnt_clear = 1'b0;
        expect_now(e);
        for (int n = 0; n < 15; n++) begin
            drive_beat(mk(16'h66AB, 8'h00, 16'h0000), 1'b1);
            expect_now(e);
            vec++;
            if (obs() !== e) begin err++; $display("FAIL cnt_hit%0d: got %b want %b", n, obs(), e); end
        end
        idle_cycle();
        expect_now(e);
        vec++;
        if (cnt_rule[3:0] !== 4'hF) begin err++; $display("FAIL cnt_full: got %0d want 15", cnt_rule[3:0]); end
        drive_beat(mk(16'h66AB, 8'h00, 16'h0000), 1'b1);
        expect_now(e);
        idle_cycle();
        expect_now(e);
        vec++;
        if (cnt_rule[3:0] !== 4'hF) begin err++; $display("FAIL cnt_sat: got %0d want 15", cnt_rule[3:0]); end
        drive_beat(mk(16'h66AB, 8'h00, 16'h0000), 1'b1);
        expect_now(e);
        cnt_clear = 1'b1;
        idle_cycle();
        cnt_clear = 1'b0;
        expect_now(e);
        vec++;
        if (cnt_rule[3:0] !== 4'h0) begin err++; $display("FAIL cnt_clr_wins: got %0d want 0", cnt_rule[3:0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_crit_multibeat();
        test_vlan_back_to_back();
        test_it_frame();
        test_backpressure();
        test_priority();
        test_reset_mid_frame();
`ifdef AXIS_CLS_COUNTERS_EN
        test_counters();
`endif
        idle_cycle();
        vec++;
        if (exp_q.size() != 0) begin
            err++;
            $display("FAIL pending: got %0d outstanding want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule : tb_axis_frame_classifier
